// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Signed support is selected at build time with the CPU_DIV_SIGNED_EN macro.
package cpu_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam int DIV_CNT_W = 5;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST_STEP = 5'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2
    } div_state_e;

    function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/cpu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module cpu_div_step
    import cpu_div_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem,
    input  logic                 dividend_bit,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH:0]   rem_next,
    output logic                 quot_bit
);

    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH+1:0] diff;

    assign shifted = {rem[DIV_WIDTH-1:0], dividend_bit};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};

    // A set rem MSB means the shifted value exceeds any 32-bit divisor.
    assign quot_bit = rem[DIV_WIDTH] | ~diff[DIV_WIDTH+1];
    assign rem_next = quot_bit ? diff[DIV_WIDTH:0] : shifted;

endmodule

// File: rtl/cpu_div_cell.sv
// Iterative 32-bit integer divider: 32 restoring steps plus a sign fix-up
// cycle, results 34 cycles after start. Signed mode needs CPU_DIV_SIGNED_EN.
module cpu_div_cell
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    input  logic             M_div_start,
    input  logic             M_div_signed,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem
);

    div_state_e state_q, state_d;

    logic [DIV_CNT_W-1:0] cnt_q;
    logic [DIV_WIDTH:0]   rem_q;
    logic [DIV_WIDTH-1:0] quot_q;
    logic [DIV_WIDTH-1:0] divisor_q;
    logic                 div_zero_q;
    logic [DIV_WIDTH-1:0] quot_out_q;
    logic [DIV_WIDTH-1:0] rem_out_q;
    logic                 done_q;

    logic [DIV_WIDTH-1:0] src1_mag;
    logic [DIV_WIDTH-1:0] src2_mag;
    logic [DIV_WIDTH-1:0] fix_quot;
    logic [DIV_WIDTH-1:0] fix_rem;
    logic [DIV_WIDTH:0]   step_rem;
    logic                 step_bit;

    cpu_div_step u_step (
        .rem          (rem_q),
        .dividend_bit (quot_q[DIV_WIDTH-1]),
        .divisor      (divisor_q),
        .rem_next     (step_rem),
        .quot_bit     (step_bit)
    );

`ifdef CPU_DIV_SIGNED_EN
    logic q_neg_q, r_neg_q;

    assign src1_mag = M_div_signed ? div_abs(M_div_src1) : M_div_src1;
    assign src2_mag = M_div_signed ? div_abs(M_div_src2) : M_div_src2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (state_q == IDLE && M_div_start) begin
            q_neg_q <= M_div_signed & (M_div_src1[DIV_WIDTH-1] ^ M_div_src2[DIV_WIDTH-1]);
            r_neg_q <= M_div_signed & M_div_src1[DIV_WIDTH-1];
        end
    end

    // Negation wraps in 32 bits, so 0x80000000 / -1 yields 0x80000000.
    assign fix_quot = div_zero_q ? DIV_ZERO_QUOT
                    : (q_neg_q ? (~quot_q + 32'd1) : quot_q);
    assign fix_rem  = r_neg_q ? (~rem_q[DIV_WIDTH-1:0] + 32'd1) : rem_q[DIV_WIDTH-1:0];
`else
    logic unused_signed;

    assign unused_signed = M_div_signed;
    assign src1_mag      = M_div_src1;
    assign src2_mag      = M_div_src2;
    assign fix_quot      = div_zero_q ? DIV_ZERO_QUOT : quot_q;
    assign fix_rem       = rem_q[DIV_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (M_div_start) state_d = ITER;
            ITER:    if (cnt_q == DIV_LAST_STEP) state_d = FIXUP;
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            div_zero_q <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (M_div_start) begin
                        quot_q     <= src1_mag;
                        divisor_q  <= src2_mag;
                        div_zero_q <= (M_div_src2 == '0);
                        rem_q      <= '0;
                        cnt_q      <= '0;
                    end
                end
                ITER: begin
                    rem_q  <= step_rem;
                    quot_q <= {quot_q[DIV_WIDTH-2:0], step_bit};
                    cnt_q  <= cnt_q + 5'd1;
                end
                FIXUP: begin
                    quot_out_q <= fix_quot;
                    rem_out_q  <= fix_rem;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign M_div_busy = (state_q != IDLE);
    assign M_div_done = done_q;
    assign M_div_quot = quot_out_q;
    assign M_div_rem  = rem_out_q;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Directed self-checking bench for cpu_div_cell; expected results are
// hand-computed, with signed expectations chosen by CPU_DIV_SIGNED_EN.
module tb_cpu_div_cell;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] M_div_src1;
    logic [31:0] M_div_src2;
    logic        M_div_start;
    logic        M_div_signed;
    logic        M_div_busy;
    logic        M_div_done;
    logic [31:0] M_div_quot;
    logic [31:0] M_div_rem;

    int vectors    = 0;
    int miscompares = 0;

    cpu_div_cell #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .M_div_src1   (M_div_src1),
        .M_div_src2   (M_div_src2),
        .M_div_start  (M_div_start),
        .M_div_signed (M_div_signed),
        .M_div_busy   (M_div_busy),
        .M_div_done   (M_div_done),
        .M_div_quot   (M_div_quot),
        .M_div_rem    (M_div_rem)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; start is high for the cycle that follows.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input bit junk, input string name);
        int  done_cyc = 0;
        int  busy_cnt = 0;
        logic busy_s, done_s;
        M_div_src1   = a;
        M_div_src2   = b;
        M_div_signed = s;
        M_div_start  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            busy_s = M_div_busy;
            done_s = M_div_done;
            M_div_start  = 1'b0;
            M_div_src1   = $urandom;
            M_div_src2   = $urandom;
            M_div_signed = 1'($urandom_range(0, 1));
            if (junk && (c == 5 || c == 20)) begin
                M_div_start  = 1'b1;
                M_div_src1   = 32'h0000_FFFF;
                M_div_src2   = 32'h0000_0001;
            end
            if (busy_s) busy_cnt++;
            if (done_s) begin
                done_cyc = c;
                break;
            end
        end
        vectors++;
        if (done_cyc !== 34) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles (0 = no done), want 34", name, done_cyc);
        end
        vectors++;
        if (busy_cnt !== 33) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d, want 33", name, busy_cnt);
        end
        vectors++;
        if (M_div_quot !== exp_q) begin
            miscompares++;
            $display("FAIL %s quot: got %h, want %h", name, M_div_quot, exp_q);
        end
        vectors++;
        if (M_div_rem !== exp_r) begin
            miscompares++;
            $display("FAIL %s rem: got %h, want %h", name, M_div_rem, exp_r);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        M_div_start  = 1'b0;
        M_div_signed = 1'b0;
        M_div_src1   = '0;
        M_div_src2   = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({M_div_busy, M_div_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset busy/done: got %b, want 00", {M_div_busy, M_div_done});
        end
        vectors++;
        if ({M_div_quot, M_div_rem} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset results: got %h/%h, want 0/0", M_div_quot, M_div_rem);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "u_100_7");
        @(negedge clk);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b0, 32'h2492_4916, 32'd2, 1'b0, "u_big_7");
        @(negedge clk);
        run_op(32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd5, 1'b0, "u_small_max");
        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, "u_max_max");
        @(negedge clk);
    endtask

    task automatic test_signed();
`ifdef CPU_DIV_SIGNED_EN
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "s_m100_7");
        @(negedge clk);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, "s_7_m2");
        @(negedge clk);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, "s_overflow");
`else
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'h2492_4916, 32'd2, 1'b0, "s_m100_7");
        @(negedge clk);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, "s_7_m2");
        @(negedge clk);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, "s_overflow");
`endif
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        run_op(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b0, "dz_unsigned");
        @(negedge clk);
        run_op(32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b0, "dz_signed");
        @(negedge clk);
        run_op(32'hFFFF_FF9C, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b0, "dz_neg");
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        run_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b1, "busy_ignore");
        @(negedge clk);
        vectors++;
        if (M_div_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore idle_after: busy got %b, want 0", M_div_busy);
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, "b2b_first");
        run_op(32'd12345, 32'd100, 1'b0, 32'd123, 32'd45, 1'b0, "b2b_second");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({M_div_done, M_div_quot, M_div_rem} !== {1'b0, 32'd123, 32'd45}) begin
                miscompares++;
                $display("FAIL hold: got done=%b %h/%h, want done=0 %h/%h",
                         M_div_done, M_div_quot, M_div_rem, 32'd123, 32'd45);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int done_seen = 0;
        M_div_src1   = 32'd1000;
        M_div_src2   = 32'd3;
        M_div_signed = 1'b0;
        M_div_start  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            M_div_start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({M_div_busy, M_div_done, M_div_quot, M_div_rem} !== 66'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b done=%b %h/%h, want 0 0 0/0",
                     M_div_busy, M_div_done, M_div_quot, M_div_rem);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (M_div_done) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL mid_reset no_done: got %0d pulses, want 0", done_seen);
        end
        run_op(32'd12345, 32'd100, 1'b0, 32'd123, 32'd45, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
